// File: rtl/acos_x.sv
// ---------------------------------------------------------------------------
// acos_x -- iterative fixed-point arc-cosine engine
//
// Computes acos(y) = pi/2 - asin(y), where asin(y) is the truncated Taylor
// series sum_{k<N} c[k] * y^(2k+1). One 16x16 multiplier is shared between
// the y^2 precompute, the coefficient MAC and the odd-power update.
// Works as the inverse of cos_x and uses the same start/done handshake.
//
// Ports
//   clk       in   1   rising-edge clock
//   rst       in   1   asynchronous, active-low reset
//   start     in   1   request, sampled only while idle
//   in_val    in   16  y, Q1.15 unsigned magnitude (two's complement when
//                      ACOS_SIGNED_IN_EN is defined)
//   in_terms  in   8   series terms N; 0 allowed; clamps to MAX_TERMS
//   out       out  16  acos(y), Q2.14 radians, unsigned, holds last result
//   busy      out  1   high from the cycle after accept through DONE state
//   done      out  1   one-cycle pulse, out valid from the same edge
//
// Build option
//   ACOS_SIGNED_IN_EN  signed input; negative y yields pi - acos(|y|)
//                      (adds the PI_FULL parameter)
// ---------------------------------------------------------------------------
module acos_x #(
    parameter int unsigned MAX_TERMS = 8,
    parameter logic [15:0] PI_HALF   = 16'd25736
`ifdef ACOS_SIGNED_IN_EN
    ,
    parameter logic [15:0] PI_FULL   = 16'd51472
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] in_val,
    input  logic [7:0]  in_terms,
    output logic [15:0] out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        MAC,
        POW,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] y;       // latched |y|, Q1.15
    logic [15:0] y2;      // y^2, Q1.15
    logic [15:0] p;       // current odd power y^(2k+1), Q1.15
    logic [17:0] acc;     // asin accumulator, Q1.15 with headroom
    logic [3:0]  k;       // term index
    logic [3:0]  n;       // latched, clamped term count
    logic        neg;     // latched input sign (always 0 without the option)

    // -----------------------------------------------------------------------
    // Input conditioning at accept: magnitude/clamp and term-count clamp
    // -----------------------------------------------------------------------
    logic [15:0] y_in;
    logic        neg_in;
    logic [3:0]  n_in;

`ifdef ACOS_SIGNED_IN_EN
    always_comb begin
        neg_in = in_val[15];
        if (in_val == 16'h8000)
            y_in = 16'h7FFF;              // |-1.0| is not representable
        else if (in_val[15])
            y_in = ~in_val + 16'd1;
        else
            y_in = in_val;
    end
`else
    assign neg_in = 1'b0;
    assign y_in   = in_val[15] ? 16'h7FFF : in_val;
`endif

    assign n_in = (in_terms > 8'(MAX_TERMS)) ? 4'(MAX_TERMS) : in_terms[3:0];

    // -----------------------------------------------------------------------
    // Coefficient ROM, c[k] = (2k)! / (4^k (k!)^2 (2k+1)), Q1.15
    // -----------------------------------------------------------------------
    function automatic logic [15:0] coef(input logic [2:0] idx);
        case (idx)
            3'd0:    coef = 16'd32768;
            3'd1:    coef = 16'd5461;
            3'd2:    coef = 16'd2458;
            3'd3:    coef = 16'd1463;
            3'd4:    coef = 16'd996;
            3'd5:    coef = 16'd733;
            3'd6:    coef = 16'd569;
            default: coef = 16'd458;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Shared multiplier. Operand selection follows the state:
    //   INIT: y*y   MAC: c[k]*p   POW: p*y2
    // Operands never exceed 0x8000 x 0x7FFF, so the >>15 result fits 16 bits.
    // -----------------------------------------------------------------------
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] prod;
    logic [15:0] prod_sh;

    always_comb begin
        mul_a = y;
        mul_b = y;
        case (state)
            MAC: begin
                mul_a = coef(k[2:0]);
                mul_b = p;
            end
            POW: begin
                mul_a = p;
                mul_b = y2;
            end
            default: ;
        endcase
    end

    assign prod    = mul_a * mul_b;
    assign prod_sh = prod[30:15];

    // -----------------------------------------------------------------------
    // Result: sat0(PI_HALF - acc/2), then optional reflection for negative y
    // -----------------------------------------------------------------------
    logic [18:0] diff;
    logic [15:0] res_pos;
    logic [15:0] res_final;

    assign diff    = {3'b000, PI_HALF} - {2'b00, acc[17:1]};
    assign res_pos = diff[18] ? '0 : diff[15:0];

`ifdef ACOS_SIGNED_IN_EN
    assign res_final = neg ? (PI_FULL - res_pos) : res_pos;
`else
    assign res_final = res_pos;
`endif

    logic unused_bits;
    assign unused_bits = ^{prod[31], prod[14:0], diff[17:16], neg};

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            out   <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
            acc   <= '0;
            k     <= '0;
            n     <= '0;
            y     <= '0;
            y2    <= '0;
            p     <= '0;
            neg   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        y     <= y_in;
                        n     <= n_in;
                        neg   <= neg_in;
                        busy  <= 1'b1;
                        state <= INIT;
                    end
                end
                INIT: begin
                    y2    <= prod_sh;
                    p     <= y;
                    acc   <= '0;
                    k     <= '0;
                    state <= (n == 4'd0) ? DONE : MAC;
                end
                MAC: begin
                    acc   <= acc + {2'b00, prod_sh};
                    state <= POW;
                end
                POW: begin
                    p     <= prod_sh;
                    k     <= k + 4'd1;
                    state <= (k + 4'd1 == n) ? DONE : MAC;
                end
                DONE: begin
                    out   <= res_final;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acos_x.sv
// ---------------------------------------------------------------------------
// tb_acos_x -- self-checking bench for acos_x
//
// A cycle-level reference (accept edge -> done 2N+2 edges later, value from
// the truncated series) is compared with out/busy/done after every clock
// edge. Directed vectors add literal values and latency checks on top.
// ---------------------------------------------------------------------------
module tb_acos_x;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in_val;
    logic [7:0]  in_terms;
    logic [15:0] out;
    logic        busy;
    logic        done;

    int nvec = 0;
    int nerr = 0;

    acos_x dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_val   (in_val),
        .in_terms (in_terms),
        .out      (out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Reference arithmetic: truncated asin series, acos = pi/2 - asin
    // -----------------------------------------------------------------------
    function automatic logic [15:0] model_acos(input logic [15:0] v, input int unsigned terms);
        longint unsigned c[8];
        longint unsigned y, y2, p, acc;
        longint          r;
        int unsigned     nt;
        bit              neg;
        c = '{32768, 5461, 2458, 1463, 996, 733, 569, 458};
        nt = (terms > 8) ? 8 : terms;
`ifdef ACOS_SIGNED_IN_EN
        neg = v[15];
        if (v == 16'h8000)  y = 32767;
        else if (v[15])     y = 65536 - longint'(v);
        else                y = v;
`else
        neg = 1'b0;
        y = v[15] ? 32767 : v;
`endif
        y2  = (y * y) >> 15;
        p   = y;
        acc = 0;
        for (int unsigned i = 0; i < nt; i++) begin
            acc += (c[i] * p) >> 15;
            p    = (p * y2) >> 15;
        end
        r = 25736 - longint'(acc >> 1);
        if (r < 0) r = 0;
        if (neg) r = 51472 - r;
        return 16'(r);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Cycle reference + compare process
    // -----------------------------------------------------------------------
    int          m_left = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_out  = '0;
    logic [15:0] m_pend = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_left = 0;
                m_busy = 1'b0;
                m_done = 1'b0;
                m_out  = '0;
            end else if (m_left == 0) begin
                m_done = 1'b0;
                if (start) begin
                    m_left = 2 * ((in_terms > 8) ? 8 : int'(in_terms)) + 2;
                    m_pend = model_acos(in_val, in_terms);
                    m_busy = 1'b1;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                    m_out  = m_pend;
                end else begin
                    m_done = 1'b0;
                end
            end
            #1;
            check("cyc_done", done, m_done);
            check("cyc_busy", busy, m_busy);
            check("cyc_out",  out,  m_out);
        end
    end

    // -----------------------------------------------------------------------
    // One operation: returns result and edges from accept to done
    // -----------------------------------------------------------------------
    task automatic op(input logic [15:0] v, input logic [7:0] t,
                      output logic [15:0] res, output int lat);
        bit got;
        @(negedge clk);
        in_val   = v;
        in_terms = t;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        got = 0;
        lat = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) got = 1;
        end
        if (!got) begin
            check("done_timeout", 0, 1);
            lat = -1;
        end
        res = out;
    endtask

    logic [15:0] r;
    int          lat;
    int          ndone;

    logic [15:0] tv_val[9]   = '{16'h0000, 16'h4000, 16'h7FFF, 16'h0000, 16'h4000,
                                 16'h2000, 16'h6000, 16'h1234, 16'h7FFF};
    logic [7:0]  tv_terms[9] = '{8'd4, 8'd8, 8'd8, 8'd0, 8'd20, 8'd3, 8'd5, 8'd1, 8'd1};

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_val   = '0;
        in_terms = '0;
        repeat (3) @(negedge clk);
        check("rst_out",  out,  0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);

        // model pinned against hand-computed values
        check("pin_model_zero", model_acos(16'h0000, 4), 25736);
        check("pin_model_half", model_acos(16'h4000, 8), 17159);
        check("pin_model_max",  model_acos(16'h7FFF, 8), 3287);

        // directed literal vectors
        op(16'h0000, 8'd4, r, lat);
        check("y0_out", r, 25736);
        check("y0_lat", lat, 10);
        op(16'h4000, 8'd8, r, lat);
        check("half_out", r, 17159);
        check("half_lat", lat, 18);
        op(16'h7FFF, 8'd8, r, lat);
        check("max_out", r, 3287);
`ifndef ACOS_SIGNED_IN_EN
        op(16'h9000, 8'd8, r, lat);
        check("clamp_out", r, 3287);
`endif
        op(16'h4000, 8'd0, r, lat);
        check("n0_out", r, 25736);
        check("n0_lat", lat, 2);
        op(16'h4000, 8'd20, r, lat);
        check("n20_out", r, 17159);
        check("n20_lat", lat, 18);

        // table sweep against the model (consecutive calls are back-to-back)
        for (int i = 0; i < 9; i++) begin
            op(tv_val[i], tv_terms[i], r, lat);
            check("tab_out", r, model_acos(tv_val[i], tv_terms[i]));
            check("tab_lat", lat, 2 * ((tv_terms[i] > 8) ? 8 : int'(tv_terms[i])) + 2);
        end

        // start pulses mid-op and in the DONE state, inputs changed after accept
        @(negedge clk);
        in_val   = 16'h4000;
        in_terms = 8'd8;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        in_val   = 16'h0000;
        in_terms = 8'd1;
        ndone    = 0;
        lat      = 0;
        r        = '0;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    r   = out;
                    lat = i;
                end
            end
            @(negedge clk);
            start = (i == 5 || i == 17);
        end
        start = 1'b0;
        check("busy_start_ndone", ndone, 1);
        check("busy_start_lat", lat, 18);
        check("busy_start_out", r, 17159);

        // asynchronous reset mid-op
        @(negedge clk);
        in_val   = 16'h4000;
        in_terms = 8'd8;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_out",  out,  0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        op(16'h2000, 8'd3, r, lat);
        check("after_rst_out", r, model_acos(16'h2000, 8'd3));
        check("after_rst_lat", lat, 8);

`ifdef ACOS_SIGNED_IN_EN
        op(16'hC000, 8'd8, r, lat);
        check("neg_half_out", r, 34313);
        check("neg_half_lat", lat, 18);
        op(16'h8000, 8'd8, r, lat);
        check("neg_one_out", r, 48185);
`endif

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, vectors %0d, miscompares %0d", nvec, nerr);
        $fatal(1);
    end

endmodule
